// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared CNN datapath constants, FSM encoding and word-address helper
//
// Purpose : common definitions for the CNN layer engines.
// Contents: LANE_W/LANES/WORD_W/BYTES_PER_WORD, max-pool FSM state type,
//           word_addr() = base + 4*((cg*h + r)*w + c).
// Build   : MAXPOOL_RELU_EN (optional, see maxpool_lane_max) selects fused ReLU.
package cnn_pkg;

    localparam int LANE_W         = 8;
    localparam int LANES          = 4;
    localparam int WORD_W         = 32;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD0,
        ST_RD1,
        ST_RD2,
        ST_RD3,
        ST_WR,
        ST_DONE
    } mp_state_e;

    // Byte address of word (cg, r, c) in a channel-group-major map of h x w words.
    function automatic logic [31:0] word_addr(
        input logic [31:0] base,
        input logic [31:0] cg,
        input logic [31:0] r,
        input logic [31:0] c,
        input logic [31:0] h,
        input logic [31:0] w
    );
        return base + 32'(BYTES_PER_WORD) * (((cg * h) + r) * w + c);
    endfunction

endpackage

// File: rtl/maxpool_lane_max.sv
// rtl/maxpool_lane_max.sv - combinational 4-lane signed int8 max of two 32-bit words
//
// Purpose : max_word lane i = max(a_word lane i, b_word lane i), signed int8,
//           lanes independent (no carry between lanes).
// Ports   : a_word   in  32  first operand
//           b_word   in  32  second operand
//           max_word out 32  lane-wise maximum
// Build   : MAXPOOL_RELU_EN defined -> negative lane results clamp to 0.
//           Clamping every partial max gives the same final word as clamping
//           only the last one, since relu(max(relu(x), y)) == relu(max(x, y)).
module maxpool_lane_max
    import cnn_pkg::*;
(
    input  logic [WORD_W-1:0] a_word,
    input  logic [WORD_W-1:0] b_word,
    output logic [WORD_W-1:0] max_word
);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic signed [LANE_W-1:0] lane_a;
        logic signed [LANE_W-1:0] lane_b;
        logic signed [LANE_W-1:0] lane_m;

        assign lane_a = a_word[i*LANE_W +: LANE_W];
        assign lane_b = b_word[i*LANE_W +: LANE_W];
        assign lane_m = (lane_a > lane_b) ? lane_a : lane_b;

`ifdef MAXPOOL_RELU_EN
        assign max_word[i*LANE_W +: LANE_W] = lane_m[LANE_W-1] ? '0 : lane_m;
`else
        assign max_word[i*LANE_W +: LANE_W] = lane_m;
`endif
    end

endmodule

// File: rtl/max_pool_2_engine.sv
// rtl/max_pool_2_engine.sv - layer-2 2x2/stride-2 max-pool engine (BRAM read -> BRAM write)
//
// Purpose : reads IN_H x IN_W x CH_GROUPS feature words, writes the
//           IN_H/2 x IN_W/2 x CH_GROUPS pooled map, one output word per 5 cycles.
// Ports   : clk, rst_n (async active-low)
//           start in (pulse), busy out, done out (pulse)
//           src_addr/src_en/src_we out, src_dout in (1-cycle read latency)
//           dst_addr/dst_din/dst_en/dst_we out (registered write port)
// Build   : MAXPOOL_RELU_EN defined -> fused ReLU on the pooled lanes.
module max_pool_2_engine
    import cnn_pkg::*;
#(
    parameter int unsigned IN_H      = 16,
    parameter int unsigned IN_W      = 16,
    parameter int unsigned CH_GROUPS = 16,
    parameter logic [31:0] SRC_BASE  = 32'h0,
    parameter logic [31:0] DST_BASE  = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [31:0] src_addr,
    output logic        src_en,
    output logic [3:0]  src_we,
    input  logic [31:0] src_dout,
    output logic [31:0] dst_addr,
    output logic [31:0] dst_din,
    output logic        dst_en,
    output logic [3:0]  dst_we
);

    if ((IN_H % 2) != 0 || (IN_W % 2) != 0 || IN_H < 2 || IN_W < 2 || CH_GROUPS < 1) begin : g_bad_cfg
        $error("max_pool_2_engine: IN_H/IN_W must be even and >= 2, CH_GROUPS >= 1");
    end

    localparam logic [31:0] H  = 32'(IN_H);
    localparam logic [31:0] W  = 32'(IN_W);
    localparam logic [31:0] OH = 32'(IN_H / 2);
    localparam logic [31:0] OW = 32'(IN_W / 2);
    localparam logic [31:0] CG = 32'(CH_GROUPS);

    mp_state_e   state_q, state_d;
    logic [31:0] cg_q, cg_d;
    logic [31:0] orow_q, orow_d;
    logic [31:0] ocol_q, ocol_d;
    logic [31:0] acc_q, acc_d;
    logic        dst_en_q, dst_en_d;
    logic [3:0]  dst_we_q, dst_we_d;
    logic [31:0] dst_addr_q, dst_addr_d;
    logic [31:0] dst_din_q, dst_din_d;
    logic        done_q, done_d;

    logic [31:0] max_word;
    logic        last_pixel;
    logic        start_ok;
    logic [31:0] row0, col0;

    maxpool_lane_max u_lane_max (
        .a_word   (acc_q),
        .b_word   (src_dout),
        .max_word (max_word)
    );

    assign last_pixel = (ocol_q == OW - 1) && (orow_q == OH - 1) && (cg_q == CG - 1);
    // done_q is high exactly in the first IDLE cycle after a run; a start there is dropped.
    assign start_ok   = start && !done_q;
    assign row0       = {orow_q[30:0], 1'b0};
    assign col0       = {ocol_q[30:0], 1'b0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cg_q       <= '0;
            orow_q     <= '0;
            ocol_q     <= '0;
            acc_q      <= '0;
            dst_en_q   <= 1'b0;
            dst_we_q   <= 4'h0;
            dst_addr_q <= '0;
            dst_din_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cg_q       <= cg_d;
            orow_q     <= orow_d;
            ocol_q     <= ocol_d;
            acc_q      <= acc_d;
            dst_en_q   <= dst_en_d;
            dst_we_q   <= dst_we_d;
            dst_addr_q <= dst_addr_d;
            dst_din_q  <= dst_din_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (start_ok) state_d = ST_RD0;
            ST_RD0:  state_d = ST_RD1;
            ST_RD1:  state_d = ST_RD2;
            ST_RD2:  state_d = ST_RD3;
            ST_RD3:  state_d = ST_WR;
            ST_WR:   state_d = last_pixel ? ST_DONE : ST_RD0;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Read-port outputs: one window word per RD state, data returns in the next state.
    always_comb begin
        src_en   = 1'b0;
        src_addr = '0;
        unique case (state_q)
            ST_RD0: begin src_en = 1'b1; src_addr = word_addr(SRC_BASE, cg_q, row0,      col0,      H, W); end
            ST_RD1: begin src_en = 1'b1; src_addr = word_addr(SRC_BASE, cg_q, row0,      col0 + 1,  H, W); end
            ST_RD2: begin src_en = 1'b1; src_addr = word_addr(SRC_BASE, cg_q, row0 + 1,  col0,      H, W); end
            ST_RD3: begin src_en = 1'b1; src_addr = word_addr(SRC_BASE, cg_q, row0 + 1,  col0 + 1,  H, W); end
            default: ;
        endcase
    end

    always_comb begin
        cg_d       = cg_q;
        orow_d     = orow_q;
        ocol_d     = ocol_q;
        acc_d      = acc_q;
        dst_en_d   = 1'b0;
        dst_we_d   = 4'h0;
        dst_addr_d = '0;
        dst_din_d  = '0;
        done_d     = (state_q == ST_DONE);
        unique case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    cg_d   = '0;
                    orow_d = '0;
                    ocol_d = '0;
                end
            end
            ST_RD1:         acc_d = src_dout;
            ST_RD2, ST_RD3: acc_d = max_word;
            ST_WR: begin
                dst_en_d   = 1'b1;
                dst_we_d   = 4'hF;
                dst_addr_d = word_addr(DST_BASE, cg_q, orow_q, ocol_q, OH, OW);
                dst_din_d  = max_word;
                if (!last_pixel) begin
                    if (ocol_q == OW - 1) begin
                        ocol_d = '0;
                        if (orow_q == OH - 1) begin
                            orow_d = '0;
                            cg_d   = cg_q + 1;
                        end else begin
                            orow_d = orow_q + 1;
                        end
                    end else begin
                        ocol_d = ocol_q + 1;
                    end
                end
            end
            default: ;
        endcase
    end

    assign busy     = (state_q != ST_IDLE);
    assign done     = done_q;
    assign src_we   = 4'h0;
    assign dst_en   = dst_en_q;
    assign dst_we   = dst_we_q;
    assign dst_addr = dst_addr_q;
    assign dst_din  = dst_din_q;

endmodule

// File: tb/tb_max_pool_2_engine.sv
// tb/tb_max_pool_2_engine.sv - self-checking bench for max_pool_2_engine (4x4x1 and 16x16x16 instances)
module tb_max_pool_2_engine;

    localparam logic [31:0] S_SRC = 32'h0000_1000;
    localparam logic [31:0] S_DST = 32'h0000_2000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic s_start, b_start;
    logic s_busy, s_done, s_src_en, s_dst_en, b_busy, b_done, b_src_en, b_dst_en;
    logic [3:0]  s_src_we, s_dst_we, b_src_we, b_dst_we;
    logic [31:0] s_src_addr, s_src_dout, s_dst_addr, s_dst_din;
    logic [31:0] b_src_addr, b_src_dout, b_dst_addr, b_dst_din;

    max_pool_2_engine #(.IN_H(4), .IN_W(4), .CH_GROUPS(1), .SRC_BASE(S_SRC), .DST_BASE(S_DST)) u_small (
        .clk(clk), .rst_n(rst_n), .start(s_start), .busy(s_busy), .done(s_done),
        .src_addr(s_src_addr), .src_en(s_src_en), .src_we(s_src_we), .src_dout(s_src_dout),
        .dst_addr(s_dst_addr), .dst_din(s_dst_din), .dst_en(s_dst_en), .dst_we(s_dst_we)
    );

    max_pool_2_engine u_big (
        .clk(clk), .rst_n(rst_n), .start(b_start), .busy(b_busy), .done(b_done),
        .src_addr(b_src_addr), .src_en(b_src_en), .src_we(b_src_we), .src_dout(b_src_dout),
        .dst_addr(b_dst_addr), .dst_din(b_dst_din), .dst_en(b_dst_en), .dst_we(b_dst_we)
    );

    // Behavioural memories and reference results.
    logic [31:0] s_src [16];
    logic [31:0] b_src [4096];
    logic [31:0] s_dst [4];
    logic [31:0] b_dst [1024];
    int          s_stamp [4];
    int          b_stamp [1024];
    logic [31:0] s_exp [4];
    logic [31:0] b_exp [1024];

    int checks = 0;
    int errors = 0;
    int run_id = 0;
    logic clr = 1'b1;

    int cyc = 0;
    int s_rd = 0, s_wr = 0, b_rd = 0, b_wr = 0, b_last = 0, gap_err = 0, bad_cnt = 0;

    logic [31:0] s_ridx, s_widx, b_ridx, b_widx;
    assign s_ridx = (s_src_addr - S_SRC) >> 2;
    assign s_widx = (s_dst_addr - S_DST) >> 2;
    assign b_ridx = b_src_addr >> 2;
    assign b_widx = b_dst_addr >> 2;

    logic bad_now;
    assign bad_now = (s_src_we != 4'h0) || (b_src_we != 4'h0)
                   || (s_dst_en ? (s_dst_we != 4'hF || s_widx >= 4)    : (s_dst_we != 4'h0))
                   || (b_dst_en ? (b_dst_we != 4'hF || b_widx >= 1024) : (b_dst_we != 4'h0))
                   || (s_src_en && s_ridx >= 16) || (b_src_en && b_ridx >= 4096);

    always @(posedge clk) begin
        if (s_src_en) s_src_dout <= s_src[s_ridx[3:0]];
        if (b_src_en) b_src_dout <= b_src[b_ridx[11:0]];
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (clr) begin
            s_rd <= 0; s_wr <= 0; b_rd <= 0; b_wr <= 0; gap_err <= 0; bad_cnt <= 0;
        end else begin
            if (s_src_en) s_rd <= s_rd + 1;
            if (b_src_en) b_rd <= b_rd + 1;
            if (s_dst_en) s_wr <= s_wr + 1;
            if (b_dst_en) begin
                b_wr   <= b_wr + 1;
                b_last <= cyc;
                if (b_wr != 0 && cyc - b_last != 5) gap_err <= gap_err + 1;
            end
            if (bad_now) bad_cnt <= bad_cnt + 1;
        end
        if (s_dst_en) begin s_dst[s_widx[1:0]] <= s_dst_din; s_stamp[s_widx[1:0]] <= run_id; end
        if (b_dst_en) begin b_dst[b_widx[9:0]] <= b_dst_din; b_stamp[b_widx[9:0]] <= run_id; end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int widx(input int cg, input int r, input int c, input int h, input int w);
        return (cg * h + r) * w + c;
    endfunction

    // Reference pooling: per lane, signed max of the four window bytes.
    function automatic logic [31:0] pool4(input logic [31:0] w0, input logic [31:0] w1,
                                          input logic [31:0] w2, input logic [31:0] w3);
        logic [31:0] res;
        int v [4];
        int m;
        for (int l = 0; l < 4; l++) begin
            v[0] = int'($signed(w0[l*8 +: 8]));
            v[1] = int'($signed(w1[l*8 +: 8]));
            v[2] = int'($signed(w2[l*8 +: 8]));
            v[3] = int'($signed(w3[l*8 +: 8]));
            m = v[0];
            for (int k = 1; k < 4; k++) if (v[k] > m) m = v[k];
`ifdef MAXPOOL_RELU_EN
            if (m < 0) m = 0;
`endif
            res[l*8 +: 8] = 8'(m);
        end
        return res;
    endfunction

    task automatic new_run();
        clr = 1'b1;
        run_id++;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic run_small(input string tag);
        bit ok;
        logic prev_en;
        int bad;
        for (int oy = 0; oy < 2; oy++)
            for (int ox = 0; ox < 2; ox++)
                s_exp[oy*2+ox] = pool4(s_src[widx(0, 2*oy, 2*ox, 4, 4)],   s_src[widx(0, 2*oy, 2*ox+1, 4, 4)],
                                       s_src[widx(0, 2*oy+1, 2*ox, 4, 4)], s_src[widx(0, 2*oy+1, 2*ox+1, 4, 4)]);
        new_run();
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        chk({tag, "_busy_after_start"}, 32'(s_busy), 32'd1);
        ok = 0;
        prev_en = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (s_done) begin ok = 1; break; end
            prev_en = s_dst_en;
            @(negedge clk);
        end
        chk({tag, "_done_seen"}, 32'(ok), 32'd1);
        chk({tag, "_last_write_then_done"}, 32'(prev_en), 32'd1);
        chk({tag, "_busy_low_at_done"}, 32'(s_busy), 32'd0);
        @(negedge clk);
        chk({tag, "_writes"}, 32'(s_wr), 32'd4);
        chk({tag, "_reads"}, 32'(s_rd), 32'd16);
        chk({tag, "_port_rules"}, 32'(bad_cnt), 32'd0);
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            chk({tag, "_word"}, s_dst[i], s_exp[i]);
            if (s_stamp[i] != run_id) bad++;
        end
        chk({tag, "_all_written"}, 32'(bad), 32'd0);
    endtask

    task automatic run_big(input string tag, input bit extras);
        bit ok;
        int bad, first_bad;
        for (int cg = 0; cg < 16; cg++)
            for (int oy = 0; oy < 8; oy++)
                for (int ox = 0; ox < 8; ox++)
                    b_exp[widx(cg, oy, ox, 8, 8)] = pool4(
                        b_src[widx(cg, 2*oy, 2*ox, 16, 16)],   b_src[widx(cg, 2*oy, 2*ox+1, 16, 16)],
                        b_src[widx(cg, 2*oy+1, 2*ox, 16, 16)], b_src[widx(cg, 2*oy+1, 2*ox+1, 16, 16)]);
        new_run();
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        ok = 0;
        for (int i = 0; i < 6000; i++) begin
            if (extras && i == 200) begin
                chk({tag, "_busy_mid_run"}, 32'(b_busy), 32'd1);
                b_start = 1'b1;
            end else begin
                b_start = 1'b0;
            end
            if (b_done) begin ok = 1; break; end
            @(negedge clk);
        end
        chk({tag, "_done_seen"}, 32'(ok), 32'd1);
        chk({tag, "_busy_low_at_done"}, 32'(b_busy), 32'd0);
        if (extras) b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        repeat (10) @(negedge clk);
        chk({tag, "_idle_after_done"}, 32'(b_busy), 32'd0);
        chk({tag, "_writes"}, 32'(b_wr), 32'd1024);
        chk({tag, "_reads"}, 32'(b_rd), 32'd4096);
        chk({tag, "_write_spacing_errs"}, 32'(gap_err), 32'd0);
        chk({tag, "_port_rules"}, 32'(bad_cnt), 32'd0);
        bad = 0;
        first_bad = -1;
        for (int i = 0; i < 1024; i++)
            if (b_dst[i] !== b_exp[i] || b_stamp[i] != run_id) begin
                bad++;
                if (first_bad < 0) first_bad = i;
            end
        if (bad != 0) $display("%s first bad word %0d: got %h want %h", tag, first_bad, b_dst[first_bad], b_exp[first_bad]);
        chk({tag, "_map_bad_words"}, 32'(bad), 32'd0);
    endtask

    initial begin
        int w0, r0;
        rst_n   = 1'b0;
        s_start = 1'b0;
        b_start = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_in_busy_done", {30'd0, s_busy | b_busy, s_done | b_done}, 32'd0);
        chk("reset_in_src", 32'({s_src_en, b_src_en}) | s_src_addr | b_src_addr, 32'd0);
        chk("reset_in_dst", 32'({s_dst_en, b_dst_en, s_dst_we, b_dst_we}) | s_dst_addr | b_dst_addr | s_dst_din | b_dst_din, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_idle_busy", 32'({s_busy, b_busy}), 32'd0);

        // 4x4x1 ramp: lane0 = word index.
        for (int i = 0; i < 16; i++) s_src[i] = 32'(i);
        run_small("ramp");
        chk("ramp_w0", s_dst[0], 32'd5);
        chk("ramp_w1", s_dst[1], 32'd7);
        chk("ramp_w2", s_dst[2], 32'd13);
        chk("ramp_w3", s_dst[3], 32'd15);

        // Directed lane-independence and all-negative windows, rest random.
        for (int i = 0; i < 16; i++) s_src[i] = $urandom;
        s_src[0] = 32'hFF01_807F;
        s_src[1] = 32'hFE02_0000;
        s_src[4] = 32'h8080_8080;
        s_src[5] = 32'h8080_8080;
        s_src[2] = 32'hF0F0_F0F0;
        s_src[3] = 32'hF1F1_F1F1;
        s_src[6] = 32'hF2F2_F2F2;
        s_src[7] = 32'hF3F3_F3F3;
        run_small("lanes");
`ifdef MAXPOOL_RELU_EN
        chk("lanes_indep", s_dst[0], 32'hFF02_007F & 32'h00FF_FFFF);
        chk("all_negative", s_dst[1], 32'h0000_0000);
`else
        chk("lanes_indep", s_dst[0], 32'hFF02_007F);
        chk("all_negative", s_dst[1], 32'hF3F3_F3F3);
`endif

        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 16; i++) s_src[i] = $urandom;
            run_small("rand_small");
        end

        // Full default map with start while busy and start in the done cycle.
        for (int i = 0; i < 4096; i++) b_src[i] = $urandom;
        run_big("big", 1'b1);

        // Abort mid-pixel by reset, then a fresh run must rewrite the whole map.
        for (int i = 0; i < 4096; i++) b_src[i] = $urandom;
        new_run();
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        repeat (302) @(negedge clk);
        chk("abort_busy_before", 32'(b_busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_outs_zero", 32'({b_busy, b_done, b_src_en, b_dst_en, b_dst_we}) | b_src_addr | b_dst_addr | b_dst_din, 32'd0);
        w0 = b_wr;
        r0 = b_rd;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("abort_no_more_writes", 32'(b_wr), 32'(w0));
        chk("abort_no_more_reads", 32'(b_rd), 32'(r0));
        chk("abort_partial_writes", 32'(w0 > 0 && w0 < 1024), 32'd1);
        run_big("rerun", 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
